updown_counter_ext: RTL
=======================

Name: updown_counter_ext

Overview:
- Parametrised up/down counter; successor to the basic load/ce/up_down counter.
- Adds a programmable upper bound (`max_val`) and a programmable step size.
- Adds four terminal modes: wrap, saturate, one-shot and bounce.
- Adds a terminal-count pulse, a sticky overflow flag and a direction readback.
- Used as the generic timer/index counter in datapath control blocks.

Parameters:
- WIDTH, 8, counter and bound width in bits.
- STEP_W, 4, step input width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_n  in  1  synchronous active-low load.
- data_load  in  WIDTH  load value.
- ce  in  1  count enable.
- up_down  in  1  1 = up, 0 = down. Ignored in BOUNCE except at load.
- step  in  STEP_W  increment magnitude.
- max_val  in  WIDTH  inclusive upper bound; the counting range is 0..max_val.
- mode  in  2  mode_e: WRAP=0, SAT=1, ONESHOT=2, BOUNCE=3.
- ovf_clr  in  1  clears the sticky ovf flag.
- count_out  out  WIDTH  counter value (registered).
- max_count  out  1  count_out == max_val (combinational from registers and max_val).
- zero  out  1  count_out == 0 (combinational).
- tc  out  1  terminal-count pulse (registered).
- ovf  out  1  sticky overflow/clip flag (registered).
- done  out  1  one-shot complete (registered).
- dir_out  out  1  current direction; 1 = up (registered).

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: count_out=0, tc=0, ovf=0, done=0, dir=1.
  - Reset takes effect immediately, including mid-operation.
- Priority: rst_n > load_n > ce. Every state change happens on a clk rising edge; latency is 1 cycle.
- Load:
  - count <= min(data_load, max_val).
  - If data_load > max_val, ovf is set.
  - done <= 0.
  - dir <= up_down.
  - tc <= 0.
- Effective step: s = min(step, max_val).
  - If step==0 or max_val==0, ce does not change count, and tc is 0.
- Out-of-range: if count > max_val (max_val lowered at runtime), the next ce cycle forces count <= max_val, sets ovf and sets tc. Mode arithmetic is skipped that cycle.
- Arithmetic: computed in WIDTH+1 bits, with no silent truncation.
  - Up event: count+s > max_val.
  - Down event: count < s.
- WRAP mode:
  - Up event: count+s-(max_val+1).
  - Down event: count+(max_val+1)-s.
  - An event sets tc and ovf.
- SAT mode:
  - Up event clamps count to max_val; down event clamps to 0.
  - tc and ovf are set on every clipping cycle, including while pinned at the bound with ce=1.
- ONESHOT mode:
  - Saturates like SAT.
  - On reaching the bound exactly or by clip, done <= 1 and tc pulses once.
  - While done=1, ce is ignored and tc=0.
  - done is cleared only by load or reset.
  - ovf is set only on a clip, not on an exact hit.
- BOUNCE mode:
  - Uses the internal dir.
  - On reaching or clipping at a bound: count = the bound, dir flips, tc=1.
  - ovf is not affected.
- tc is a 1-cycle pulse per event. It is 0 on any cycle with ce=0 or load.
- ovf:
  - Stays set until ovf_clr=1.
  - If ovf_clr and a set event occur in the same cycle, set wins (ovf stays 1).
- A mode change takes effect on the next edge. done is not cleared by a mode change.
- dir_out tracks up_down in non-BOUNCE modes (registered each cycle).

Decomposition:
- Package counter_ext_pkg:
  - mode_e enum (2-bit).
  - Localparams for mode encodings.
  - Width helper functions shared by the bench model.
- Sub-module updown_step_calc (combinational):
  - Inputs: count, s, max_val, dir, mode.
  - Outputs: next count, event, clip, flip.
  - The top holds the registers, the priority logic and the one-shot/bounce state.

Test Plan:
1. count=0x37, rst_n pulled low between edges -> count_out=0 and zero=1 immediately; ovf=0, done=0, dir_out=1.
2. WRAP, max_val=9, count=8, step=3, up, ce=1 -> count=1, tc=1 for one cycle, ovf=1; assert ovf_clr for one cycle -> ovf=0.
3. SAT, max_val=200, count=2, step=5, down -> count=0, zero=1, tc=1; next cycle stays 0 with tc=1. Assert ovf_clr simultaneously with the clip -> ovf stays 1.
4. ONESHOT, max_val=5, count=3, step=2, up -> count=5, done=1, tc pulses once, ovf=0; 3 more ce cycles -> count stays 5, tc=0; load 0 -> done=0.
5. BOUNCE, max_val=4, step=3, load 0 with up_down=1 -> count sequence 3, 4 (tc, dir_out=0), 1, 0 (tc, dir_out=1), 3; ovf stays 0.
6. max_val=10, load 0xF0 -> count=10, max_count=1, ovf=1. Then max_val=6 with ce=1 -> count=6, tc=1.

Source files
------------

// File: rtl/counter_ext_pkg.sv
// Shared types and helpers for the extended up/down counter family.
package counter_ext_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2,
        BOUNCE  = 2'd3
    } mode_e;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_BOUNCE  = 2'd3;

    // Unsigned minimum; callers zero-extend narrower operands to 32 bits.
    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // True when a value lies beyond the inclusive bound.
    function automatic logic above_bound(input int unsigned val, input int unsigned bound);
        return (val > bound);
    endfunction

endpackage

// File: rtl/updown_step_calc.sv
// Combinational next-count calculator for one counting step in each terminal mode.
module updown_step_calc
    import counter_ext_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] max_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             evt,
    output logic             clip,
    output logic             flip
);

    logic [WIDTH:0]   cnt_ext_s;
    logic [WIDTH:0]   s_ext_s;
    logic [WIDTH:0]   max_ext_s;
    logic [WIDTH:0]   lim_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   wrap_up_s;
    logic [WIDTH:0]   wrap_dn_s;
    logic [WIDTH-1:0] plain_s;
    logic [WIDTH-1:0] bound_s;
    logic             over_s;
    logic             hit_s;
    mode_e            mode_s;

    // Extended-width operands so the bound comparisons never lose a carry.
    always_comb begin
        mode_s    = mode_e'(mode);
        cnt_ext_s = {1'b0, count};
        s_ext_s   = {1'b0, s};
        max_ext_s = {1'b0, max_val};
        lim_s     = max_ext_s + (WIDTH + 1)'(1);
        sum_s     = cnt_ext_s + s_ext_s;
        wrap_up_s = sum_s - lim_s;
        wrap_dn_s = cnt_ext_s + lim_s - s_ext_s;
        if (dir) begin
            over_s  = (sum_s > max_ext_s);
            hit_s   = (sum_s == max_ext_s);
            plain_s = sum_s[WIDTH-1:0];
            bound_s = max_val;
        end else begin
            over_s  = (cnt_ext_s < s_ext_s);
            hit_s   = (cnt_ext_s == s_ext_s);
            plain_s = count - s;
            bound_s = {WIDTH{1'b0}};
        end
    end

    // Mode-specific terminal handling; clip marks steps that must raise ovf.
    always_comb begin
        next_count = count;
        evt        = 1'b0;
        clip       = 1'b0;
        flip       = 1'b0;
        case (mode_s)
            WRAP: begin
                if (over_s) begin
                    next_count = dir ? wrap_up_s[WIDTH-1:0] : wrap_dn_s[WIDTH-1:0];
                    evt        = 1'b1;
                    clip       = 1'b1;
                end else begin
                    next_count = plain_s;
                end
            end
            SAT: begin
                if (over_s) begin
                    next_count = bound_s;
                    evt        = 1'b1;
                    clip       = 1'b1;
                end else begin
                    next_count = plain_s;
                end
            end
            ONESHOT: begin
                if (over_s) begin
                    next_count = bound_s;
                    evt        = 1'b1;
                    clip       = 1'b1;
                end else if (hit_s) begin
                    next_count = bound_s;
                    evt        = 1'b1;
                end else begin
                    next_count = plain_s;
                end
            end
            BOUNCE: begin
                if (over_s || hit_s) begin
                    next_count = bound_s;
                    evt        = 1'b1;
                    flip       = 1'b1;
                end else begin
                    next_count = plain_s;
                end
            end
            default: begin
                next_count = count;
            end
        endcase
    end

endmodule

// File: rtl/updown_counter_ext.sv
// Up/down counter with programmable bound and step, four terminal modes,
// terminal-count pulse, sticky overflow and direction readback.
module updown_counter_ext
    import counter_ext_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              ce,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic [1:0]        mode,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              tc,
    output logic              ovf,
    output logic              done,
    output logic              dir_out
);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;
    logic             done_r;
    logic             dir_r;

    logic [WIDTH-1:0] s_s;
    logic [WIDTH-1:0] load_val_s;
    logic             load_ovf_s;
    logic             oor_s;
    logic             advance_s;
    logic             dir_eff_s;
    logic             ovf_set_s;
    logic [WIDTH-1:0] next_s;
    logic             evt_s;
    logic             clip_s;
    logic             flip_s;

    // Effective step, load clamp and gating; s==0 covers both step==0 and max_val==0.
    always_comb begin
        s_s        = WIDTH'(umin(32'(step), 32'(max_val)));
        load_ovf_s = above_bound(32'(data_load), 32'(max_val));
        load_val_s = load_ovf_s ? max_val : data_load;
        oor_s      = above_bound(32'(count_r), 32'(max_val));
        advance_s  = ce && !done_r && (s_s != {WIDTH{1'b0}});
        dir_eff_s  = (mode == MODE_BOUNCE) ? dir_r : up_down;
    end

    updown_step_calc #(
        .WIDTH (WIDTH)
    ) u_step_calc (
        .count      (count_r),
        .s          (s_s),
        .max_val    (max_val),
        .dir        (dir_eff_s),
        .mode       (mode),
        .next_count (next_s),
        .evt        (evt_s),
        .clip       (clip_s),
        .flip       (flip_s)
    );

    // Overflow set sources; load outranks counting.
    always_comb begin
        ovf_set_s = 1'b0;
        if (!load_n) begin
            ovf_set_s = load_ovf_s;
        end else if (advance_s) begin
            ovf_set_s = oor_s || clip_s;
        end else begin
            ovf_set_s = 1'b0;
        end
    end

    // Counter state: reset > load > count enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            dir_r   <= 1'b1;
        end else begin
            // A set in the same cycle as ovf_clr keeps the flag high.
            ovf_r <= ovf_set_s || (ovf_r && !ovf_clr);
            if (!load_n) begin
                count_r <= load_val_s;
                tc_r    <= 1'b0;
                done_r  <= 1'b0;
                dir_r   <= up_down;
            end else begin
                if (advance_s && oor_s) begin
                    count_r <= max_val;
                    tc_r    <= 1'b1;
                end else if (advance_s) begin
                    count_r <= next_s;
                    tc_r    <= evt_s;
                    if (mode == MODE_ONESHOT && evt_s) begin
                        done_r <= 1'b1;
                    end else begin
                        done_r <= done_r;
                    end
                end else begin
                    tc_r <= 1'b0;
                end
                if (mode != MODE_BOUNCE) begin
                    dir_r <= up_down;
                end else if (advance_s && !oor_s && flip_s) begin
                    dir_r <= !dir_r;
                end else begin
                    dir_r <= dir_r;
                end
            end
        end
    end

    assign count_out = count_r;
    assign tc        = tc_r;
    assign ovf       = ovf_r;
    assign done      = done_r;
    assign dir_out   = dir_r;
    assign max_count = (count_r == max_val);
    assign zero      = (count_r == {WIDTH{1'b0}});

endmodule
